// File: rtl/config_pkg.sv
// Shared build configuration for the branch-predictor update path.
// Holds the queue entry layout, the commit width and the cfg_t record
// that parameterises bp_update_queue and its storage.
package config_pkg;

  // Number of resolved branches that can arrive from commit in one cycle.
  localparam int COMMIT_WIDTH = 2;

  // Widest history snapshot an entry can carry; narrower builds zero-extend.
  localparam int GHR_MAX_BITS = 32;

  // One pending predictor update: branch PC, fetch-time history and outcome.
  typedef struct packed {
    logic [31:0]             pc;
    logic [GHR_MAX_BITS-1:0] ghr;
    logic                    taken;
  } entry_t;

  // Build-wide configuration shared by the predictor blocks.
  typedef struct packed {
    int unsigned depth;
    int unsigned ghrBits;
  } cfg_t;

  localparam cfg_t DefaultCfg = '{depth: 8, ghrBits: 8};

endpackage

// File: rtl/bp_upd_fifo_2w1r.sv
// Circular buffer with two write ports and one read port.
// Write port 1 is only used together with write port 0, so the two
// writes always land on consecutive slots starting at the tail.
// Occupancy is tracked by an explicit count so that full and empty are
// never confused when head and tail point at the same slot.
module bp_upd_fifo_2w1r
  import config_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr0_en_i,
  input  entry_t        wr0_data_i,
  input  logic          wr1_en_i,
  input  entry_t        wr1_data_i,
  input  logic          rd_en_i,
  output entry_t        rd_data_o,
  output logic [CW-1:0] count_o
);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW-1:0] tail1;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    numWr;

  assign tail1     = tail_q + AW'(1);
  assign rd_data_o = mem_q[head_q];
  assign count_o   = count_q;

  // Next pointers and occupancy; power-of-two depth makes the wrap free.
  always_comb begin
    numWr   = 2'(wr0_en_i) + 2'(wr1_en_i);
    tail_d  = tail_q + AW'(numWr);
    head_d  = head_q + AW'(rd_en_i);
    count_d = count_q + CW'(numWr) - CW'(rd_en_i);
  end

  // Pointer and count registers, cleared by the synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr0_en_i) begin
      mem_q[tail_q] <= wr0_data_i;
    end
    if (wr1_en_i) begin
      mem_q[tail1] <= wr1_data_i;
    end
  end

endmodule

// File: rtl/bp_update_queue.sv
// Branch-predictor update queue: buffers up to two resolved branches per
// cycle from commit and replays them one per cycle to the predictor.
// Optional feature macro: BPU_UPD_FILTER_EN -- when defined, lanes that
// were predicted confidently and correctly are dropped instead of queued
// and counted in filtered_cnt_o; when undefined every accepted lane is
// queued and filtered_cnt_o is tied to zero.
module bp_update_queue
  import config_pkg::*;
#(
  parameter  cfg_t Cfg      = DefaultCfg,
  parameter  int   DEPTH    = int'(Cfg.depth),
  parameter  int   GHR_BITS = int'(Cfg.ghrBits),
  localparam int   CW       = $clog2(DEPTH) + 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [COMMIT_WIDTH-1:0]             commit_valid_i,
  input  logic [COMMIT_WIDTH-1:0][31:0]       commit_pc_i,
  input  logic [COMMIT_WIDTH-1:0][GHR_BITS-1:0] commit_ghr_i,
  input  logic [COMMIT_WIDTH-1:0]             commit_taken_i,
  input  logic [COMMIT_WIDTH-1:0]             commit_confident_i,
  input  logic [COMMIT_WIDTH-1:0]             commit_mispredict_i,
  output logic                                commit_ready_o,
  output logic                                update_valid_o,
  output logic [31:0]                         update_pc_o,
  output logic [GHR_BITS-1:0]                 update_ghr_o,
  output logic                                update_taken_o,
  input  logic                                update_stall_i,
  output logic [CW-1:0]                       count_o,
  output logic [15:0]                         filtered_cnt_o
);

  logic [COMMIT_WIDTH-1:0] accept;
  logic [COMMIT_WIDTH-1:0] keep;
  logic [COMMIT_WIDTH-1:0] filtered;
  entry_t                  laneEntry [COMMIT_WIDTH];
  logic                    wr0En;
  logic                    wr1En;
  entry_t                  wr0Data;
  entry_t                  wr1Data;
  logic                    pop;
  entry_t                  headEntry;
  logic [CW-1:0]           count;

  // Readiness looks only at the registered count: two free slots needed,
  // with no credit for an entry leaving in the same cycle.
  assign commit_ready_o = (count <= CW'(DEPTH - 2));

  assign update_valid_o = (count != '0);
  assign update_pc_o    = headEntry.pc;
  assign update_ghr_o   = headEntry.ghr[GHR_BITS-1:0];
  assign update_taken_o = headEntry.taken;
  assign count_o        = count;

  // The head stays put while the predictor stalls, so outputs hold.
  assign pop = update_valid_o & ~update_stall_i;

  // Per-lane acceptance, optional filtering and entry formatting.
  always_comb begin
    accept   = '0;
    keep     = '0;
    filtered = '0;
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      laneEntry[l]       = '0;
      laneEntry[l].pc    = commit_pc_i[l];
      laneEntry[l].ghr   = GHR_MAX_BITS'(commit_ghr_i[l]);
      laneEntry[l].taken = commit_taken_i[l];
      accept[l]          = commit_valid_i[l] & commit_ready_o;
`ifdef BPU_UPD_FILTER_EN
      filtered[l] = accept[l] & commit_confident_i[l] & ~commit_mispredict_i[l];
`else
      filtered[l] = 1'b0;
`endif
      keep[l] = accept[l] & ~filtered[l];
    end
  end

  // Compact surviving lanes onto the FIFO write ports, oldest first, so a
  // lone lane 1 still lands exactly at the tail.
  always_comb begin
    wr0En   = keep[0] | keep[1];
    wr1En   = keep[0] & keep[1];
    wr0Data = keep[0] ? laneEntry[0] : laneEntry[1];
    wr1Data = laneEntry[1];
  end

  bp_upd_fifo_2w1r #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr0_en_i   (wr0En),
    .wr0_data_i (wr0Data),
    .wr1_en_i   (wr1En),
    .wr1_data_i (wr1Data),
    .rd_en_i    (pop),
    .rd_data_o  (headEntry),
    .count_o    (count)
  );

`ifdef BPU_UPD_FILTER_EN
  logic [15:0] filtCnt_q, filtCnt_d;
  logic [16:0] filtSum;

  // Saturating accumulation of lanes dropped by the filter.
  always_comb begin
    filtSum   = {1'b0, filtCnt_q} + 17'(filtered[0]) + 17'(filtered[1]);
    filtCnt_d = filtSum[16] ? 16'hFFFF : filtSum[15:0];
  end

  // Filtered-branch counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filtCnt_q <= '0;
    end else begin
      filtCnt_q <= filtCnt_d;
    end
  end

  assign filtered_cnt_o = filtCnt_q;
`else
  assign filtered_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_bp_update_queue.sv
// Self-checking bench for bp_update_queue (default configuration, DEPTH=8).
// Stimulus pushes expected updates into a scoreboard; a monitor on the
// falling edge compares every presented update against the oldest entry.
module tb_bp_update_queue;

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  ghr;
    logic        taken;
  } exp_t;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [1:0]      commit_valid_i = '0;
  logic [1:0][31:0] commit_pc_i = '0;
  logic [1:0][7:0] commit_ghr_i = '0;
  logic [1:0]      commit_taken_i = '0;
  logic [1:0]      commit_confident_i = '0;
  logic [1:0]      commit_mispredict_i = '0;
  logic            commit_ready_o;
  logic            update_valid_o;
  logic [31:0]     update_pc_o;
  logic [7:0]      update_ghr_o;
  logic            update_taken_o;
  logic            update_stall_i = 1'b0;
  logic [3:0]      count_o;
  logic [15:0]     filtered_cnt_o;

  exp_t sb[$];
  int   passCount = 0;
  int   totalCount = 0;

  bp_update_queue dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .commit_valid_i      (commit_valid_i),
    .commit_pc_i         (commit_pc_i),
    .commit_ghr_i        (commit_ghr_i),
    .commit_taken_i      (commit_taken_i),
    .commit_confident_i  (commit_confident_i),
    .commit_mispredict_i (commit_mispredict_i),
    .commit_ready_o      (commit_ready_o),
    .update_valid_o      (update_valid_o),
    .update_pc_o         (update_pc_o),
    .update_ghr_o        (update_ghr_o),
    .update_taken_o      (update_taken_o),
    .update_stall_i      (update_stall_i),
    .count_o             (count_o),
    .filtered_cnt_o      (filtered_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one commit cycle; accepted, unfiltered lanes go into the scoreboard.
  task automatic applyStimulus(input logic [1:0] v,
                               input logic [31:0] pc0, input logic [7:0] g0, input logic t0,
                               input logic c0, input logic m0,
                               input logic [31:0] pc1, input logic [7:0] g1, input logic t1,
                               input logic c1, input logic m1,
                               input bit expectAccept);
    logic [1:0] c;
    logic [1:0] m;
    exp_t       e [2];
    c = {c1, c0};
    m = {m1, m0};
    e[0] = '{pc: pc0, ghr: g0, taken: t0};
    e[1] = '{pc: pc1, ghr: g1, taken: t1};
    commit_valid_i      = v;
    commit_pc_i         = {pc1, pc0};
    commit_ghr_i        = {g1, g0};
    commit_taken_i      = {t1, t0};
    commit_confident_i  = c;
    commit_mispredict_i = m;
    if (expectAccept) begin
      for (int l = 0; l < 2; l++) begin
        if (v[l]) begin
`ifdef BPU_UPD_FILTER_EN
          if (!(c[l] && !m[l])) sb.push_back(e[l]);
`else
          sb.push_back(e[l]);
`endif
        end
      end
    end
    @(posedge clk_i);
    #1;
    commit_valid_i = '0;
  endtask

  // Wait (bounded) for the queue to empty, then confirm the scoreboard did too.
  task automatic drainWait(input string name);
    int n;
    n = 0;
    while (count_o != 0 && n < 40) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    checkOutput({name, "_count"}, 32'(count_o), 32'd0);
    checkOutput({name, "_sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every presented update must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (!rst_i && update_valid_o) begin
      totalCount++;
      if (sb.size() == 0) begin
        $display("[TB] FAIL update_unexpected: got pc 0x%0h expected no update", update_pc_o);
      end else if (update_pc_o === sb[0].pc && update_ghr_o === sb[0].ghr &&
                   update_taken_o === sb[0].taken) begin
        passCount++;
        if (!update_stall_i) void'(sb.pop_front());
      end else begin
        $display("[TB] FAIL update_data: got pc 0x%0h ghr 0x%0h t %0b expected pc 0x%0h ghr 0x%0h t %0b",
                 update_pc_o, update_ghr_o, update_taken_o, sb[0].pc, sb[0].ghr, sb[0].taken);
        if (!update_stall_i) void'(sb.pop_front());
      end
    end
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checkOutput("rst_count", 32'(count_o), 32'd0);
    checkOutput("rst_valid", 32'(update_valid_o), 32'd0);
    checkOutput("rst_ready", 32'(commit_ready_o), 32'd1);
    checkOutput("rst_filt", 32'(filtered_cnt_o), 32'd0);

    // Single lane 0, visible the cycle after the write edge, gone one later.
    applyStimulus(2'b01, 32'h8000_0010, 8'h5A, 1'b1, 1'b0, 1'b0,
                  32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("single_valid", 32'(update_valid_o), 32'd1);
    checkOutput("single_pc", update_pc_o, 32'h8000_0010);
    checkOutput("single_ghr", 32'(update_ghr_o), 32'h5A);
    @(posedge clk_i);
    #1;
    checkOutput("single_valid_after", 32'(update_valid_o), 32'd0);

    // Two lanes in one cycle, issued in lane order.
    applyStimulus(2'b11, 32'h100, 8'h01, 1'b0, 1'b0, 1'b0,
                  32'h104, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("dual_count", 32'(count_o), 32'd2);
    drainWait("dual");

    // Fill to full under stall; ready drops at 8 and an extra push is dropped.
    update_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, 32'h200 + 32'(8*i), 8'(8'h10 + 2*i), 1'(i), 1'b0, 1'b0,
                    32'h204 + 32'(8*i), 8'(8'h11 + 2*i), 1'(~i), 1'b0, 1'b0, 1'b1);
      if (i == 2) begin
        checkOutput("fill6_count", 32'(count_o), 32'd6);
        checkOutput("fill6_ready", 32'(commit_ready_o), 32'd1);
      end
    end
    checkOutput("full_count", 32'(count_o), 32'd8);
    checkOutput("full_ready", 32'(commit_ready_o), 32'd0);
    applyStimulus(2'b11, 32'h300, 8'hEE, 1'b1, 1'b0, 1'b0,
                  32'h304, 8'hEF, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("drop_count", 32'(count_o), 32'd8);
    checkOutput("stall_pc", update_pc_o, 32'h200);
    update_stall_i = 1'b0;
    drainWait("full");

    // Refill with three entries after the wrap, including a lone lane 1.
    update_stall_i = 1'b1;
    applyStimulus(2'b11, 32'h400, 8'h40, 1'b1, 1'b0, 1'b0,
                  32'h404, 8'h41, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b10, 32'hDEAD, 8'hFF, 1'b0, 1'b0, 1'b0,
                  32'h408, 8'h42, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("refill_count", 32'(count_o), 32'd3);
    update_stall_i = 1'b0;
    drainWait("refill");

    // Reset mid-operation with five queued entries.
    update_stall_i = 1'b1;
    applyStimulus(2'b11, 32'h600, 8'h60, 1'b0, 1'b0, 1'b0,
                  32'h604, 8'h61, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b11, 32'h608, 8'h62, 1'b0, 1'b0, 1'b0,
                  32'h60C, 8'h63, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b01, 32'h610, 8'h64, 1'b0, 1'b0, 1'b0,
                  32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("pre_rst_count", 32'(count_o), 32'd5);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    sb.delete();
    update_stall_i = 1'b0;
    checkOutput("mid_rst_count", 32'(count_o), 32'd0);
    checkOutput("mid_rst_valid", 32'(update_valid_o), 32'd0);
    checkOutput("mid_rst_filt", 32'(filtered_cnt_o), 32'd0);
    checkOutput("mid_rst_ready", 32'(commit_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    checkOutput("post_rst_valid", 32'(update_valid_o), 32'd0);

    // Confident-correct lane 0 with a mispredicted lane 1.
    update_stall_i = 1'b1;
    applyStimulus(2'b11, 32'h500, 8'h50, 1'b1, 1'b1, 1'b0,
                  32'h504, 8'h51, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef BPU_UPD_FILTER_EN
    checkOutput("filt_cnt", 32'(filtered_cnt_o), 32'd1);
    checkOutput("filt_count", 32'(count_o), 32'd1);
    checkOutput("filt_head", update_pc_o, 32'h504);
`else
    checkOutput("filt_cnt", 32'(filtered_cnt_o), 32'd0);
    checkOutput("filt_count", 32'(count_o), 32'd2);
    checkOutput("filt_head", update_pc_o, 32'h500);
`endif
    update_stall_i = 1'b0;
    drainWait("filter");

    repeat (2) @(posedge clk_i);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
